alu_rol_seq: RTL



---
 rtl/alu_rol_seq_pkg.sv | 21 ++
 rtl/alu_rol_seq_if.sv | 42 ++++
 rtl/alu_rol_stage.sv | 33 +++
 rtl/alu_rol_seq.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_rol_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_rol_seq_pkg
// Brief    : Shared ALU constants and the alu_rol_seq state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_rol_seq_pkg;

    localparam int c_ALU_WIDTH = 32;

    // ALU function-select code that routes an instruction to the rotate-left unit
    localparam logic [4:0] c_ALU_OP_ROL = 5'b01011;

    typedef logic [1:0] rol_state_t;

    localparam rol_state_t c_ST_IDLE = 2'd0;
    localparam rol_state_t c_ST_RUN  = 2'd1;
    localparam rol_state_t c_ST_DONE = 2'd2;

endpackage : alu_rol_seq_pkg
`default_nettype wire

// File: rtl/alu_rol_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rol_seq_if
// Brief    : Start/done handshake and operand/result bus of the rotate-left unit.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rol_seq_if
    import alu_rol_seq_pkg::*;
#(
    parameter int WIDTH = c_ALU_WIDTH
) ();

    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [WIDTH-1:0]   data_input;
    logic [SHAMT_W-1:0] num_rotates;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   data_output;

    // master: the control unit issuing rotates
    modport master (
        output start,
        output data_input,
        output num_rotates,
        input  busy,
        input  done,
        input  data_output
    );

    modport slave (
        input  start,
        input  data_input,
        input  num_rotates,
        output busy,
        output done,
        output data_output
    );

endinterface : alu_rol_seq_if
`default_nettype wire

// File: rtl/alu_rol_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_rol_stage
// Brief    : One log-shifter stage: rotate left by 2^step when enabled.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rol_stage
    import alu_rol_seq_pkg::*;
#(
    parameter int WIDTH = c_ALU_WIDTH
) (
    input  wire logic [WIDTH-1:0]         i_vec,
    input  wire logic [$clog2(WIDTH)-1:0] i_step,
    input  wire logic                     i_en,
    output logic      [WIDTH-1:0]         o_vec
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W:0]     w_dist;
    logic [2*WIDTH-1:0]   w_dbl;
    logic [WIDTH-1:0]     w_rot;

    // The upper half of {v,v} shifted left by d is v rotated left by d.
    always_comb begin
        w_dist = {{SHAMT_W{1'b0}}, 1'b1} << i_step;
        w_dbl  = {i_vec, i_vec};
        w_rot  = WIDTH'((w_dbl << w_dist) >> WIDTH);
        o_vec  = i_en ? w_rot : i_vec;
    end

endmodule : alu_rol_stage
`default_nettype wire

// File: rtl/alu_rol_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_rol_seq
// Brief    : Multi-cycle rotate-left unit, one log-shifter stage per clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rol_seq
    import alu_rol_seq_pkg::*;
#(
    parameter int WIDTH = c_ALU_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     clr,
    alu_rol_seq_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [SHAMT_W-1:0] c_LAST_STEP = SHAMT_W'(SHAMT_W - 1);
    localparam logic [SHAMT_W-1:0] c_STEP_ONE  = SHAMT_W'(1);

    rol_state_t         r_state_q, w_state_d;
    logic [SHAMT_W-1:0] r_step_q,  w_step_d;
    logic [WIDTH-1:0]   r_work_q,  w_work_d;
    logic [SHAMT_W-1:0] r_amt_q,   w_amt_d;
    logic [WIDTH-1:0]   r_dout_q,  w_dout_d;

    logic               w_stage_en;
    logic [WIDTH-1:0]   w_stage_out;

    // Selecting amt[step] by masking keeps the index width-independent.
    assign w_stage_en = |(r_amt_q & (c_STEP_ONE << r_step_q));

    alu_rol_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_vec  (r_work_q),
        .i_step (r_step_q),
        .i_en   (w_stage_en),
        .o_vec  (w_stage_out)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_step_d  = r_step_q;
        w_work_d  = r_work_q;
        w_amt_d   = r_amt_q;
        w_dout_d  = r_dout_q;

        case (r_state_q)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    w_work_d  = bus.data_input;
                    w_amt_d   = bus.num_rotates;
                    w_step_d  = '0;
                    w_state_d = c_ST_RUN;
                end else begin
                    w_state_d = c_ST_IDLE;
                end
            end

            c_ST_RUN: begin
                w_work_d = w_stage_out;
                if (r_step_q == c_LAST_STEP) begin
                    w_dout_d  = w_stage_out;
                    w_step_d  = '0;
                    w_state_d = c_ST_DONE;
                end else begin
                    w_step_d  = r_step_q + c_STEP_ONE;
                end
            end

            default: begin
                w_state_d = c_ST_IDLE;
                w_step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state_q <= c_ST_IDLE;
            r_step_q  <= '0;
            r_work_q  <= '0;
            r_amt_q   <= '0;
            r_dout_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_step_q  <= w_step_d;
            r_work_q  <= w_work_d;
            r_amt_q   <= w_amt_d;
            r_dout_q  <= w_dout_d;
        end
    end

    assign bus.busy        = (r_state_q == c_ST_RUN);
    assign bus.done        = (r_state_q == c_ST_DONE);
    assign bus.data_output = r_dout_q;

endmodule : alu_rol_seq
`default_nettype wire
